mul_arbiter: RTL and testbench



---
 rtl/mul_arbiter_pkg.sv | 13 +
 rtl/mul_arbiter_array_mul.sv | 44 ++++
 rtl/mul_arbiter.sv | 126 ++++++++++++
 tb/tb_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM encoding
// and the width of a requester index.
package mul_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int REQ_IDX_W = 1;

endpackage

// File: rtl/mul_arbiter_array_mul.sv
// Baugh-Wooley array multiplier producing the exact N+M-bit product;
// i_k = 1 selects two's-complement operands, i_k = 0 unsigned.
module Array_MUL #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic [N-1:0]   i_a,
   input  logic [M-1:0]   i_b,
   input  logic           i_k,
   output logic [N+M-1:0] o_p
);

   localparam int P = N + M;

   logic [P-1:0] w_acc;
   logic [P-1:0] w_row;
   logic         w_pp;

   // In signed mode the partial products that pair exactly one sign bit are
   // inverted. The correction constant 2^(N-1) + 2^(M-1) + 2^(P-1) then
   // turns the sum into the two's-complement product, modulo 2^P.
   always_comb begin
      w_acc = '0;
      w_row = '0;
      w_pp  = 1'b0;
      if (i_k) begin
         w_acc = (P'(1) << (N - 1)) + (P'(1) << (M - 1)) + (P'(1) << (P - 1));
      end
      for (int j = 0; j < M; j++) begin
         w_row = '0;
         for (int i = 0; i < N; i++) begin
            w_pp = i_a[i] & i_b[j];
            if ((i == N - 1) != (j == M - 1)) begin
               w_pp = w_pp ^ i_k;
            end
            w_row = w_row | (P'(w_pp) << (i + j));
         end
         w_acc = w_acc + w_row;
      end
   end

   assign o_p = w_acc;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that sequences two valid/ready requesters onto one
// shared array multiplier, with registered operands and a registered product.
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid_0,
   input  logic           req_valid_1,
   output logic           req_ready_0,
   output logic           req_ready_1,
   input  logic [N-1:0]   req_a_0,
   input  logic [N-1:0]   req_a_1,
   input  logic [M-1:0]   req_b_0,
   input  logic [M-1:0]   req_b_1,
   input  logic           req_signed_0,
   input  logic           req_signed_1,
   output logic           resp_valid_0,
   output logic           resp_valid_1,
   input  logic           resp_ready_0,
   input  logic           resp_ready_1,
   output logic [N+M-1:0] resp_out,
   output logic           busy
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [N-1:0]           r_op_a;
   logic [M-1:0]           r_op_b;
   logic                   r_op_k;
   logic [REQ_IDX_W-1:0]   r_owner;
   logic [REQ_IDX_W-1:0]   r_last_grant;
   logic [N+M-1:0]         r_result;
   logic [N+M-1:0]         w_product;
   logic                   w_grant_vld;
   logic [REQ_IDX_W-1:0]   w_grant;
   logic                   w_accept;
   logic                   w_resp_take;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      w_grant_vld = req_valid_0 | req_valid_1;
      w_grant     = 1'b0;
      if (req_valid_0 && req_valid_1) begin
         w_grant = ~r_last_grant;
      end else if (req_valid_1) begin
         w_grant = 1'b1;
      end
   end

   assign w_accept    = (r_state == IDLE) && w_grant_vld && !rst;
   assign w_resp_take = (r_owner == 1'b1) ? resp_ready_1 : resp_ready_0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = CALC;
         CALC:    w_state_nxt = RESP;
         RESP:    if (w_resp_take) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready is gated by rst so nothing can appear accepted on a reset edge.
   always_comb begin
      req_ready_0  = (r_state == IDLE) && !rst && w_grant_vld && (w_grant == 1'b0);
      req_ready_1  = (r_state == IDLE) && !rst && w_grant_vld && (w_grant == 1'b1);
      resp_valid_0 = (r_state == RESP) && (r_owner == 1'b0);
      resp_valid_1 = (r_state == RESP) && (r_owner == 1'b1);
      busy         = (r_state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_k       <= 1'b0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_result     <= '0;
      end else begin
         if (w_accept) begin
            r_op_a       <= (w_grant == 1'b1) ? req_a_1 : req_a_0;
            r_op_b       <= (w_grant == 1'b1) ? req_b_1 : req_b_0;
            r_op_k       <= (w_grant == 1'b1) ? req_signed_1 : req_signed_0;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
         end
         if (r_state == CALC) begin
            r_result <= w_product;
         end
      end
   end

   Array_MUL #(
      .N (N),
      .M (M)
   ) u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .i_k (r_op_k),
      .o_p (w_product)
   );

   assign resp_out = r_result;

   a_one_resp_valid: assert property (@(posedge clk) disable iff (rst)
      !(resp_valid_0 && resp_valid_1));
   a_one_req_ready: assert property (@(posedge clk) disable iff (rst)
      !(req_ready_0 && req_ready_1));
   a_resp_stable: assert property (@(posedge clk)
      (((resp_valid_0 && !resp_ready_0) || (resp_valid_1 && !resp_ready_1)) && !rst)
      |=> $stable(resp_out));

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus random traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_mul_arbiter;

   localparam int N = 8;
   localparam int M = 8;
   localparam int P = N + M;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_0, req_valid_1;
   logic         req_ready_0, req_ready_1;
   logic [N-1:0] req_a_0, req_a_1;
   logic [M-1:0] req_b_0, req_b_1;
   logic         req_signed_0, req_signed_1;
   logic         resp_valid_0, resp_valid_1;
   logic         resp_ready_0, resp_ready_1;
   logic [P-1:0] resp_out;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mul_arbiter #(.N(N), .M(M)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_0  (req_valid_0),
      .req_valid_1  (req_valid_1),
      .req_ready_0  (req_ready_0),
      .req_ready_1  (req_ready_1),
      .req_a_0      (req_a_0),
      .req_a_1      (req_a_1),
      .req_b_0      (req_b_0),
      .req_b_1      (req_b_1),
      .req_signed_0 (req_signed_0),
      .req_signed_1 (req_signed_1),
      .resp_valid_0 (resp_valid_0),
      .resp_valid_1 (resp_valid_1),
      .resp_ready_0 (resp_ready_0),
      .resp_ready_1 (resp_ready_1),
      .resp_out     (resp_out),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [P-1:0] ref_mul(input logic [N-1:0] a, input logic [M-1:0] b,
                                            input logic s);
      longint sa, sb;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = a;
         sb = b;
      end
      return P'(sa * sb);
   endfunction

   function automatic int exp_grant(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // Transaction model: m_cnt counts clock edges since the accepting edge.
   bit           m_init = 1'b0;
   bit           m_busy = 1'b0;
   bit           m_last = 1'b1;
   int           m_owner = 0;
   int           m_cnt = 0;
   logic [P-1:0] m_prod = '0;

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_init = 1'b1;
         m_busy = 1'b0;
         m_last = 1'b1;
         m_owner = 0;
         m_cnt = 0;
      end else if (m_init) begin
         if (!m_busy) begin
            g = exp_grant(req_valid_0, req_valid_1, m_last);
            if (g >= 0) begin
               m_busy  = 1'b1;
               m_cnt   = 1;
               m_owner = g;
               m_last  = (g == 1);
               m_prod  = (g == 1) ? ref_mul(req_a_1, req_b_1, req_signed_1)
                                  : ref_mul(req_a_0, req_b_0, req_signed_0);
            end
         end else if (m_cnt >= 2 && ((m_owner == 1) ? resp_ready_1 : resp_ready_0)) begin
            m_busy = 1'b0;
         end else if (m_cnt < 2) begin
            m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      int  g;
      bit  ev0, ev1;
      if (m_init) begin
         g   = exp_grant(req_valid_0, req_valid_1, m_last);
         ev0 = m_busy && m_cnt >= 2 && m_owner == 0;
         ev1 = m_busy && m_cnt >= 2 && m_owner == 1;
         chk("rdy0", req_ready_0, (!rst && !m_busy && g == 0));
         chk("rdy1", req_ready_1, (!rst && !m_busy && g == 1));
         chk("vld0", resp_valid_0, ev0);
         chk("vld1", resp_valid_1, ev1);
         chk("busy", busy, m_busy);
         if (ev0 || ev1) chk("out", resp_out, m_prod);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid_0 = 0; req_valid_1 = 0;
      req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
      req_signed_0 = 0; req_signed_1 = 0;
      resp_ready_0 = 1; resp_ready_1 = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      req_valid_0 = 1;
      rst = 1;
      tick();
      @(negedge clk);
      chk("rst_rdy0", req_ready_0, 0);
      tick();
      rst = 0;
      req_valid_0 = 0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_out", resp_out, 0);
      chk("rst_vld0", resp_valid_0, 0);
      chk("rst_vld1", resp_valid_1, 0);
      tick();
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      chk({tag, "_idle"}, ok, 1);
      tick();
   endtask

   task automatic send(input int idx, input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic s, input logic [P-1:0] exp, input string tag);
      bit ok = 0;
      resp_ready_0 = 1; resp_ready_1 = 1;
      if (idx == 0) begin
         req_valid_0 = 1; req_a_0 = a; req_b_0 = b; req_signed_0 = s;
      end else begin
         req_valid_1 = 1; req_a_1 = a; req_b_1 = b; req_signed_1 = s;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if ((idx == 0) ? req_ready_0 : req_ready_1) begin
            ok = 1;
            break;
         end
      end
      chk({tag, "_acc"}, ok, 1);
      tick();
      req_valid_0 = 0; req_valid_1 = 0;
      if (ok) begin
         @(negedge clk);
         chk({tag, "_calc"}, (idx == 0) ? resp_valid_0 : resp_valid_1, 0);
         @(negedge clk);
         chk({tag, "_vld"}, (idx == 0) ? resp_valid_0 : resp_valid_1, 1);
         chk({tag, "_oth"}, (idx == 0) ? resp_valid_1 : resp_valid_0, 0);
         chk({tag, "_out"}, resp_out, exp);
         tick();
         @(negedge clk);
         chk({tag, "_done"}, busy, 0);
         tick();
      end
   endtask

   task automatic contend(input int first, input string tag);
      int idx_q[$];
      int cyc_q[$];
      bit d0, d1;
      req_valid_0 = 1; req_a_0 = 8'd7;   req_b_0 = 8'd9;  req_signed_0 = 0;
      req_valid_1 = 1; req_a_1 = 8'hF6;  req_b_1 = 8'd11; req_signed_1 = 1;
      resp_ready_0 = 1; resp_ready_1 = 1;
      for (int c = 0; c < 30 && idx_q.size() < 2; c++) begin
         @(negedge clk);
         d0 = req_valid_0 && req_ready_0;
         d1 = req_valid_1 && req_ready_1;
         if (d0) begin idx_q.push_back(0); cyc_q.push_back(c); end
         if (d1) begin idx_q.push_back(1); cyc_q.push_back(c); end
         tick();
         if (d0) req_valid_0 = 0;
         if (d1) req_valid_1 = 0;
      end
      req_valid_0 = 0; req_valid_1 = 0;
      chk({tag, "_n"}, idx_q.size(), 2);
      if (idx_q.size() == 2) begin
         chk({tag, "_first"}, idx_q[0], first);
         chk({tag, "_second"}, idx_q[1], 1 - first);
         chk({tag, "_gap"}, cyc_q[1] - cyc_q[0], 3);
      end
      wait_idle(tag);
   endtask

   function automatic logic [N-1:0] rand_op();
      logic [N-1:0] e [4];
      e[0] = '0; e[1] = 8'h80; e[2] = 8'h7F; e[3] = 8'hFF;
      if ($urandom_range(0, 3) == 0) return e[$urandom_range(0, 3)];
      return N'($urandom);
   endfunction

   initial begin
      bit ok;
      idle_inputs();
      rst = 1;
      tick();
      do_reset();

      send(0, 8'd200, 8'd3, 0, 16'h0258, "u_basic");
      send(1, 8'hFD, 8'h05, 1, 16'hFFF1, "s_small");
      send(0, 8'h80, 8'h80, 1, 16'h4000, "s_min");
      send(1, 8'h80, 8'h80, 0, 16'h4000, "u_80");
      send(0, 8'hFF, 8'hFF, 0, 16'hFE01, "u_ff");
      send(1, 8'hFF, 8'hFF, 1, 16'h0001, "s_ff");

      do_reset();
      contend(0, "cont_a");
      send(0, 8'd12, 8'd12, 0, 16'd144, "solo0");
      contend(1, "cont_b");

      // Backpressure with requester 1 waiting the whole time.
      ok = 0;
      req_valid_0 = 1; req_a_0 = 8'h12; req_b_0 = 8'h34; req_signed_0 = 0;
      resp_ready_0 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready_0) begin ok = 1; break; end
      end
      chk("bp_acc", ok, 1);
      tick();
      req_valid_0 = 0;
      req_valid_1 = 1; req_a_1 = 8'd2; req_b_1 = 8'd3; req_signed_1 = 0;
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_vld", resp_valid_0, 1);
         chk("bp_out", resp_out, 16'h03A8);
         chk("bp_rdy1", req_ready_1, 0);
         chk("bp_busy", busy, 1);
         tick();
      end
      resp_ready_0 = 1;
      tick();
      @(negedge clk);
      chk("bp_rel_busy", busy, 0);
      chk("bp_rel_rdy1", req_ready_1, 1);
      tick();
      req_valid_1 = 0;
      wait_idle("bp");

      // Reset while in CALC.
      ok = 0;
      req_valid_0 = 1; req_a_0 = 8'd5; req_b_0 = 8'd5; req_signed_0 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready_0) begin ok = 1; break; end
      end
      chk("mr_acc", ok, 1);
      tick();
      req_valid_0 = 0;
      rst = 1;
      @(negedge clk);
      chk("mr_calc_busy", busy, 1);
      tick();
      rst = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mr_busy", busy, 0);
         chk("mr_vld0", resp_valid_0, 0);
         chk("mr_vld1", resp_valid_1, 0);
         if (c == 0) chk("mr_out", resp_out, 0);
         tick();
      end
      send(0, 8'd5, 8'd5, 0, 16'd25, "mr_after");

      // Random traffic, checked cycle by cycle by the model.
      for (int i = 0; i < 1500; i++) begin
         rst          = ($urandom_range(0, 199) == 0);
         req_valid_0  = ($urandom_range(0, 2) != 0);
         req_valid_1  = ($urandom_range(0, 2) != 0);
         req_a_0      = rand_op();
         req_a_1      = rand_op();
         req_b_0      = rand_op();
         req_b_1      = rand_op();
         req_signed_0 = 1'($urandom);
         req_signed_1 = 1'($urandom);
         resp_ready_0 = ($urandom_range(0, 3) != 0);
         resp_ready_1 = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 0;
      idle_inputs();
      wait_idle("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
